// File: rtl/stream_counter_gen_pkg.sv
// Shared types and lane arithmetic for the stream counter source; STREAM_COUNTER_GEN_SATURATE_EN selects clamping.
// Latency: none (types and a pure function).
// Backpressure: not applicable.
package stream_counter_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand width of the lane function; lanes up to 32 bits wide are supported.
    localparam int unsigned LV_W = 32;

    // base +/- index*step, either wrapped to width bits or clamped at 0 / 2^width-1.
    function automatic logic [LV_W-1:0] lane_value(
        input logic [LV_W-1:0] base,
        input logic [LV_W-1:0] index,
        input logic [LV_W-1:0] step,
        input logic            down,
        input int unsigned     width
    );
        logic [65:0]     prod;
        logic [65:0]     lim;
        logic [LV_W-1:0] res;
`ifdef STREAM_COUNTER_GEN_SATURATE_EN
        logic [65:0]     sum;
`endif
        prod = 66'(index) * 66'(step);
        lim  = (66'(1) << width) - 66'd1;
`ifdef STREAM_COUNTER_GEN_SATURATE_EN
        if (down) begin
            res = (prod > 66'(base)) ? '0 : LV_W'(66'(base) - prod);
        end else begin
            sum = 66'(base) + prod;
            res = (sum > lim) ? LV_W'(lim) : LV_W'(sum);
        end
`else
        res = down ? LV_W'(66'(base) - prod) : LV_W'(66'(base) + prod);
        res = res & LV_W'(lim);
`endif
        return res;
    endfunction

endpackage

// File: rtl/stream_counter_lane.sv
// One output lane: holds its value and steps it by NUM_CHANNELS*step per accepted beat.
// Latency: value registered, updates the cycle after load/adv.
// Backpressure: holds its value whenever adv is low.
module stream_counter_lane
    import stream_counter_gen_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 2,
    parameter int LANE         = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  adv,
    input  logic [DATA_WIDTH-1:0] init,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic                  down,
    output logic [DATA_WIDTH-1:0] value
);

    // Saturation is idempotent along one direction, so stepping the clamped
    // value by NUM_CHANNELS*step matches computing each beat from init directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= DATA_WIDTH'(lane_value(LV_W'(init), LV_W'(LANE), LV_W'(step),
                                            down, DATA_WIDTH));
        end else if (adv) begin
            value <= DATA_WIDTH'(lane_value(LV_W'(value), LV_W'(NUM_CHANNELS), LV_W'(step),
                                            down, DATA_WIDTH));
        end
    end

endmodule

// File: rtl/stream_counter_gen.sv
// Multi-lane AXI-Stream counter burst source; STREAM_COUNTER_GEN_SATURATE_EN clamps lanes instead of wrapping.
// Latency: beat 0 valid one cycle after cfg_start, then one beat per cycle; done one cycle after the last beat.
// Backpressure: tdata/tlast held while tvalid && !tready; tvalid never depends on tready.
module stream_counter_gen
    import stream_counter_gen_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 2,
    parameter int BURST_LEN    = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_start,
    input  logic [DATA_WIDTH-1:0]              cfg_init,
    input  logic [DATA_WIDTH-1:0]              cfg_step,
    input  logic                               cfg_down,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic                               busy,
    output logic                               done
);

    localparam int              CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t                state;
    logic [CNT_W-1:0]      beat_cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [DATA_WIDTH-1:0] step_q;
    logic                  down_q;
    logic [DATA_WIDTH-1:0] lane_step;
    logic                  lane_down;
    logic                  load;
    logic                  fire;
    logic                  adv;

    assign load      = (state == IDLE) && cfg_start;
    assign fire      = m_axis_tvalid && m_axis_tready;
    assign adv       = fire && !m_axis_tlast;
    assign cnt_nxt   = beat_cnt + CNT_W'(1);
    // Lanes see the live config on the start cycle and the latched copy afterwards.
    assign lane_step = load ? cfg_step : step_q;
    assign lane_down = load ? cfg_down : down_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            step_q        <= '0;
            down_q        <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state         <= RUN;
                        beat_cnt      <= '0;
                        step_q        <= cfg_step;
                        down_q        <= cfg_down;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (BURST_LEN == 1);
                        busy          <= 1'b1;
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (m_axis_tlast) begin
                            state         <= DONE;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            beat_cnt     <= cnt_nxt;
                            m_axis_tlast <= (cnt_nxt == LAST_CNT);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
        stream_counter_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .NUM_CHANNELS (NUM_CHANNELS),
            .LANE         (c)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .adv   (adv),
            .init  (cfg_init),
            .step  (lane_step),
            .down  (lane_down),
            .value (m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_stream_counter_gen.sv
// Self-checking bench for stream_counter_gen: constant vector table, corner sequences, random bursts vs. arithmetic model.
module tb_stream_counter_gen;

    localparam int DW = 8;
    localparam int NC = 2;
    localparam int BL = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_start;
    logic [DW-1:0]     cfg_init;
    logic [DW-1:0]     cfg_step;
    logic              cfg_down;
    logic [NC*DW-1:0]  tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [NC*DW-1:0] beats [BL];

    typedef struct {
        logic [7:0]  init;
        logic [7:0]  step;
        logic        down;
        logic [15:0] b0;
        logic [15:0] b1;
        logic [15:0] b15;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    stream_counter_gen #(
        .DATA_WIDTH   (DW),
        .NUM_CHANNELS (NC),
        .BURST_LEN    (BL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_init      (cfg_init),
        .cfg_step      (cfg_step),
        .cfg_down      (cfg_down),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Lane c of beat b is init +/- (b*NC + c)*step, wrapped or clamped to DW bits.
    function automatic logic [NC*DW-1:0] exp_beat(input logic [7:0] init, input logic [7:0] step,
                                                  input logic down, input int b);
        logic [NC*DW-1:0] r;
        int v;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            v = down ? int'(init) - (b*NC + c)*int'(step) : int'(init) + (b*NC + c)*int'(step);
`ifdef STREAM_COUNTER_GEN_SATURATE_EN
            if (v > (1 << DW) - 1) v = (1 << DW) - 1;
            if (v < 0) v = 0;
`endif
            r[c*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    // rmode: 0 = always ready, 1 = ready pattern 1-0-0-1, 2 = random ready.
    // pulse: keep cfg_start high through RUN and DONE to show it is ignored.
    task automatic run_burst(input logic [7:0] init, input logic [7:0] step, input logic down,
                             input int rmode, input bit pulse);
        int               nb;
        int               k;
        bit               stalled;
        logic [NC*DW-1:0] prev_d;
        logic             prev_l;
        cfg_init  = init;
        cfg_step  = step;
        cfg_down  = down;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = pulse;
        cfg_init  = DW'($urandom);
        cfg_step  = DW'($urandom);
        cfg_down  = 1'($urandom);
        chk("start_busy", 64'(busy), 64'(1));
        nb      = 0;
        k       = 0;
        stalled = 1'b0;
        prev_d  = '0;
        prev_l  = 1'b0;
        while (nb < BL && k < 400) begin
            chk("run_vld", 64'(tvalid), 64'(1));
            chk("run_done", 64'(done), 64'(0));
            if (stalled) begin
                chk("hold_dat", 64'(tdata), 64'(prev_d));
                chk("hold_last", 64'(tlast), 64'(prev_l));
            end
            case (rmode)
                0:       tready = 1'b1;
                1:       tready = ((k % 4) == 0) || ((k % 4) == 3);
                default: tready = ($urandom_range(0, 3) != 0);
            endcase
            if (tvalid && tready) begin
                chk("beat_dat", 64'(tdata), 64'(exp_beat(init, step, down, nb)));
                chk("beat_last", 64'(tlast), 64'(nb == BL - 1));
                beats[nb] = tdata;
                nb++;
                stalled = 1'b0;
            end else begin
                stalled = tvalid;
            end
            prev_d = tdata;
            prev_l = tlast;
            @(posedge clk); #1;
            k++;
        end
        chk("burst_len", 64'(nb), 64'(BL));
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_vld", 64'(tvalid), 64'(0));
        chk("done_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_vld", 64'(tvalid), 64'(0));
        if (pulse) begin
            cfg_start = 1'b0;
            @(posedge clk); #1;
            chk("ignored_start", 64'(tvalid), 64'(0));
        end
    endtask

    initial begin
`ifdef STREAM_COUNTER_GEN_SATURATE_EN
        vecs[0] = '{init: 8'h00, step: 8'd1, down: 1'b0, b0: 16'h0100, b1: 16'h0302, b15: 16'h1F1E};
        vecs[1] = '{init: 8'hF0, step: 8'd8, down: 1'b0, b0: 16'hF8F0, b1: 16'hFFFF, b15: 16'hFFFF};
        vecs[2] = '{init: 8'h05, step: 8'd3, down: 1'b1, b0: 16'h0205, b1: 16'h0000, b15: 16'h0000};
        vecs[3] = '{init: 8'h80, step: 8'd0, down: 1'b1, b0: 16'h8080, b1: 16'h8080, b15: 16'h8080};
`else
        vecs[0] = '{init: 8'h00, step: 8'd1, down: 1'b0, b0: 16'h0100, b1: 16'h0302, b15: 16'h1F1E};
        vecs[1] = '{init: 8'h05, step: 8'd3, down: 1'b1, b0: 16'h0205, b1: 16'hFCFF, b15: 16'hA8AB};
        vecs[2] = '{init: 8'hFE, step: 8'd1, down: 1'b0, b0: 16'hFFFE, b1: 16'h0100, b15: 16'h1D1C};
        vecs[3] = '{init: 8'h80, step: 8'd0, down: 1'b1, b0: 16'h8080, b1: 16'h8080, b15: 16'h8080};
`endif
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_init  = '0;
        cfg_step  = '0;
        cfg_down  = 1'b0;
        tready    = 1'b0;
        #3;
        chk("rst_vld", 64'(tvalid), 64'(0));
        chk("rst_last", 64'(tlast), 64'(0));
        chk("rst_dat", 64'(tdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back table bursts also exercise the earliest restart.
        for (int i = 0; i < 4; i++) begin
            run_burst(vecs[i].init, vecs[i].step, vecs[i].down, 0, 1'b0);
            chk("tbl_b0", 64'(beats[0]), 64'(vecs[i].b0));
            chk("tbl_b1", 64'(beats[1]), 64'(vecs[i].b1));
            chk("tbl_b15", 64'(beats[15]), 64'(vecs[i].b15));
        end

        run_burst(8'h10, 8'h07, 1'b0, 1, 1'b0);
        run_burst(8'h33, 8'h05, 1'b1, 0, 1'b1);

        // Reset while beat 7 is presented.
        cfg_init  = 8'h40;
        cfg_step  = 8'h02;
        cfg_down  = 1'b0;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        tready    = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
        end
        tready = 1'b0;
        chk("pre_rst_vld", 64'(tvalid), 64'(1));
        chk("pre_rst_dat", 64'(tdata), 64'(exp_beat(8'h40, 8'h02, 1'b0, 7)));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(tvalid), 64'(0));
        chk("mid_rst_last", 64'(tlast), 64'(0));
        chk("mid_rst_dat", 64'(tdata), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_vld", 64'(tvalid), 64'(0));
        run_burst(8'h40, 8'h02, 1'b0, 0, 1'b0);
        chk("fresh_b0", 64'(beats[0]), 64'(exp_beat(8'h40, 8'h02, 1'b0, 0)));

        for (int i = 0; i < 6; i++) begin
            run_burst(8'($urandom), 8'($urandom), 1'($urandom), 2, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
